// File: rtl/pipe_pkg.sv
// pipe_pkg: shared state encoding, widths and capture helpers for pipe_stage_reg.
package pipe_pkg;
   typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} pipe_state_t;
   localparam int OCC_W = 2;
   localparam int CTRL_MAX_W = 64;
   function automatic logic [CTRL_MAX_W-1:0] apply_kill(input logic [CTRL_MAX_W-1:0] ctrl, input logic kill);
      return kill ? '0 : ctrl;
   endfunction
endpackage

// File: rtl/pipe_slot.sv
// pipe_slot: one payload/control/error register with load enable and async active-low clear.
module pipe_slot #(
   parameter int DATA_W = 64,
   parameter int CTRL_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load_i,
   input  logic [DATA_W-1:0] data_i,
   input  logic [CTRL_W-1:0] ctrl_i,
   input  logic              err_i,
   output logic [DATA_W-1:0] data_o,
   output logic [CTRL_W-1:0] ctrl_o,
   output logic              err_o
);
   logic [DATA_W-1:0] data_q;
   logic [CTRL_W-1:0] ctrl_q;
   logic              err_q;
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         data_q <= '0;
         ctrl_q <= '0;
         err_q  <= 1'b0;
      end else if (load_i) begin
         data_q <= data_i;
         ctrl_q <= ctrl_i;
         err_q  <= err_i;
      end
   assign data_o = data_q;
   assign ctrl_o = ctrl_q;
   assign err_o  = err_q;
endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: valid/ready pipeline register with kill-to-bubble, error OR and flush.
// Define PIPE_STAGE_SKID_EN for the two-entry build with a registered in_ready.
module pipe_stage_reg
   import pipe_pkg::*;
#(
   parameter int DATA_W = 64,
   parameter int CTRL_W = 8,
   parameter int ERR_N  = 3,
   parameter int KILL_N = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic [CTRL_W-1:0] in_ctrl,
   input  logic [ERR_N-1:0]  in_err,
   input  logic [KILL_N-1:0] kill,
   input  logic              flush,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic              out_err,
   output logic [OCC_W-1:0]  occ
);
   pipe_state_t       state_q, state_d;
   logic              in_fire, out_fire, head_load;
   logic [CTRL_W-1:0] cap_ctrl, head_ctrl_d;
   logic [DATA_W-1:0] head_data_d;
   logic              cap_err, head_err_d;
   assign out_valid = state_q != EMPTY;
   assign occ       = OCC_W'(state_q);
   assign in_fire   = in_valid & in_ready;
   assign out_fire  = out_valid & out_ready;
   assign cap_ctrl  = CTRL_W'(apply_kill(CTRL_MAX_W'(in_ctrl), |kill));
   assign cap_err   = |in_err;
`ifdef PIPE_STAGE_SKID_EN
   logic              skid_load;
   logic [DATA_W-1:0] skid_data;
   logic [CTRL_W-1:0] skid_ctrl;
   logic              skid_err;
   // in_ready depends only on held state, cutting the path from out_ready
   assign in_ready = rst & (state_q != TWO);
   always_comb begin
      state_d   = state_q;
      head_load = 1'b0;
      skid_load = 1'b0;
      case (state_q)
         EMPTY: if (in_fire) begin
            state_d   = ONE;
            head_load = 1'b1;
         end
         ONE: if (in_fire & out_fire) head_load = 1'b1;
            else if (in_fire) begin
               state_d   = TWO;
               skid_load = 1'b1;
            end else if (out_fire) state_d = EMPTY;
         TWO: if (out_fire) begin
            state_d   = ONE;
            head_load = 1'b1;
         end
         default: state_d = EMPTY;
      endcase
      if (flush) begin
         state_d   = EMPTY;
         head_load = 1'b0;
         skid_load = 1'b0;
      end
   end
   assign head_data_d = (state_q == TWO) ? skid_data : in_data;
   assign head_ctrl_d = (state_q == TWO) ? skid_ctrl : cap_ctrl;
   assign head_err_d  = (state_q == TWO) ? skid_err  : cap_err;
   pipe_slot #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_skid (
      .clk(clk), .rst(rst), .load_i(skid_load),
      .data_i(in_data), .ctrl_i(cap_ctrl), .err_i(cap_err),
      .data_o(skid_data), .ctrl_o(skid_ctrl), .err_o(skid_err)
   );
`else
   assign in_ready = rst & (!out_valid | out_ready);
   always_comb begin
      state_d   = flush ? EMPTY : in_fire ? ONE : out_fire ? EMPTY : state_q;
      head_load = in_fire & !flush;
   end
   assign head_data_d = in_data;
   assign head_ctrl_d = cap_ctrl;
   assign head_err_d  = cap_err;
`endif
   always_ff @(posedge clk or negedge rst)
      if (!rst) state_q <= EMPTY;
      else state_q <= state_d;
   pipe_slot #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_head (
      .clk(clk), .rst(rst), .load_i(head_load),
      .data_i(head_data_d), .ctrl_i(head_ctrl_d), .err_i(head_err_d),
      .data_o(out_data), .ctrl_o(out_ctrl), .err_o(out_err)
   );
endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: directed plus random stimulus against a queue-based model with a decoupled monitor.
module tb_pipe_stage_reg;
`ifdef PIPE_STAGE_SKID_EN
   localparam int CAP = 2;
`else
   localparam int CAP = 1;
`endif
   typedef struct {logic [63:0] d; logic [7:0] c; logic e;} ent_t;
   logic        clk = 1'b0, rst;
   logic        in_valid, in_ready, flush, out_valid, out_ready, out_err;
   logic [63:0] in_data, out_data;
   logic [7:0]  in_ctrl, out_ctrl;
   logic [2:0]  in_err;
   logic [1:0]  kill, occ;
   ent_t        exp_q[$];
   int          held = 0;
   int          vectors = 0, miscompares = 0;
   pipe_stage_reg dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .in_ctrl(in_ctrl), .in_err(in_err), .kill(kill), .flush(flush), .out_valid(out_valid),
      .out_ready(out_ready), .out_data(out_data), .out_ctrl(out_ctrl), .out_err(out_err), .occ(occ)
   );
   always #5 clk = ~clk;
   function automatic bit accepts(int n, logic ordy);
      return (CAP == 2) ? (n < 2) : (n == 0 || ordy);
   endfunction
   task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
      end
   endtask
   // model: the stage is a FIFO of capacity CAP, updated at the clock edge
   initial forever begin
      bit inf, outf;
      @(posedge clk or negedge rst);
      if (!rst) begin
         exp_q.delete();
         held = 0;
      end else begin
         outf = held != 0 && out_ready;
         inf  = in_valid && accepts(held, out_ready);
         if (flush) begin
            exp_q.delete();
            held = 0;
         end else begin
            if (inf) exp_q.push_back('{in_data, (kill != 0) ? 8'h00 : in_ctrl, in_err != 0});
            held = held - int'(outf) + int'(inf);
         end
      end
   end
   initial forever begin
      ent_t e;
      @(negedge clk);
      chk("in_ready", 64'(in_ready), 64'(rst && accepts(held, out_ready)));
      chk("out_valid", 64'(out_valid), 64'(held != 0));
      chk("occ", 64'(occ), 64'(held));
      if (!rst) begin
         chk("rst_data", out_data, 64'h0);
         chk("rst_ctrl", 64'(out_ctrl), 64'h0);
         chk("rst_err", 64'(out_err), 64'h0);
      end
      if (out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL pop: got out_valid=1 want no entry at %0t", $time);
         end else begin
            e = exp_q.pop_front();
            chk("out_data", out_data, e.d);
            chk("out_ctrl", 64'(out_ctrl), 64'(e.c));
            chk("out_err", 64'(out_err), 64'(e.e));
         end
      end
   end
   task automatic step(logic v, logic [63:0] d, logic [7:0] c, logic [1:0] k, logic [2:0] er, logic ordy, logic fl);
      in_valid = v; in_data = d; in_ctrl = c; kill = k; in_err = er; out_ready = ordy; flush = fl;
      @(posedge clk);
      #1;
   endtask
   initial begin
      rst = 1'b0; in_valid = 1'b1; in_data = 64'h55; in_ctrl = 8'hFF; kill = '0;
      in_err = '0; flush = 1'b0; out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      for (int i = 0; i < 16; i++) step(1, 64'h10 + 64'(i), 8'h3C, 2'b00, 3'b000, 1, 0);
      step(1, 64'hAB, 8'hA5, 2'b10, 3'b000, 1, 0);
      step(1, 64'hAC, 8'hA5, 2'b00, 3'b000, 1, 0);
      step(1, 64'h01, 8'h11, 2'b00, 3'b010, 1, 0);
      step(1, 64'h02, 8'h11, 2'b00, 3'b000, 1, 0);
      step(0, 64'h0, 8'h0, 2'b00, 3'b000, 1, 0);
      step(1, 64'hA, 8'h0A, 2'b00, 3'b000, 0, 0);
      step(1, 64'hB, 8'h0B, 2'b00, 3'b000, 0, 0);
      repeat (2) step(1, 64'hC, 8'h0C, 2'b00, 3'b000, 0, 0);
      repeat (2) step(1, 64'hC, 8'h0C, 2'b00, 3'b000, 1, 0);
      repeat (3) step(0, 64'h0, 8'h0, 2'b00, 3'b000, 1, 0);
      step(1, 64'hA1, 8'h01, 2'b00, 3'b000, 0, 0);
      step(1, 64'hB1, 8'h02, 2'b00, 3'b000, 0, 0);
      step(1, 64'hD1, 8'h03, 2'b00, 3'b000, 0, 1);
      repeat (2) step(0, 64'h0, 8'h0, 2'b00, 3'b000, 1, 0);
      for (int i = 0; i < 800; i++) begin
         step($urandom_range(3) != 0, {$urandom, $urandom}, 8'($urandom),
              ($urandom_range(3) == 0) ? 2'($urandom_range(3, 1)) : 2'b00,
              ($urandom_range(2) == 0) ? 3'($urandom) : 3'b000,
              $urandom_range(2) != 0, $urandom_range(39) == 0);
         if (i == 400) begin
            #2 rst = 1'b0;
            repeat (2) @(posedge clk);
            #1 rst = 1'b1;
         end
      end
      in_valid = 1'b0; out_ready = 1'b1; flush = 1'b0;
      for (int i = 0; i < 10 && held != 0; i++) begin
         @(posedge clk);
         #1;
      end
      chk("drain", 64'(exp_q.size()), 64'h0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
